lfsr_seq_checker: RTL

//  Receive-side checker for the muxed Galois LFSR generator. Takes the generator's

---
 rtl/lfsr_seq_checker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the muxed Galois LFSR generator.
// Self-synchronises a local predictor to the incoming state word, declares lock
// after a run of consecutive matches, then flags and counts every mismatch.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   SEARCH | no predictor; waiting for a non-zero word to seed from
//   VERIFY | seeded; counting consecutive matches toward lock
//   LOCKED | tracking; mismatches pulse err, bump err_cnt, flywheel pred
module lfsr_seq_checker #(
    parameter int             W        = 3,
    parameter logic [W-1:0]   TAPS     = 3'b001,
    parameter int             LOCK_CNT = 4,
    parameter int             LOSS_CNT = 3,
    parameter int             CNT_W    = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [W-1:0]     din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic             zero_det,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W-1:0]     exp_word
);

    // run_cnt only ever holds 0..LOCK_CNT-1 and miss_cnt 0..LOSS_CNT-1,
    // because reaching the last value always changes state instead.
    localparam int RUN_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int MISS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [W-1:0]       pred, pred_nxt;
    logic [RUN_W-1:0]   run_cnt, run_nxt;
    logic [MISS_W-1:0]  miss_cnt, miss_nxt;
    logic               err_nxt;
    logic               zero_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               din_match;
    logic               din_zero;

    function automatic logic [W-1:0] lfsr_nxt(input logic [W-1:0] s);
        return {s[0], s[W-1:1]} ^ ({W{s[0]}} & TAPS);
    endfunction

    assign din_match = (din == pred);
    assign din_zero  = (din == '0);
    // pred is forced to zero whenever the checker is in SEARCH
    assign exp_word  = pred;

    // State and output registers; everything returns to idle on reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= SEARCH;
            pred     <= '0;
            run_cnt  <= '0;
            miss_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            zero_det <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            pred     <= pred_nxt;
            run_cnt  <= run_nxt;
            miss_cnt <= miss_nxt;
            locked   <= (state_nxt == LOCKED);
            err      <= err_nxt;
            zero_det <= zero_nxt;
            err_cnt  <= cnt_nxt;
        end
    end

    // Next-state, predictor and run/miss counters; nothing moves without din_vld
    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        run_nxt   = run_cnt;
        miss_nxt  = miss_cnt;
        if (din_vld) begin
            case (state)
                SEARCH: begin
                    if (!din_zero) begin
                        pred_nxt  = lfsr_nxt(din);
                        run_nxt   = '0;
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (din_match) begin
                        pred_nxt = lfsr_nxt(pred);
                        if (run_cnt == RUN_LAST) begin
                            state_nxt = LOCKED;
                            run_nxt   = '0;
                            miss_nxt  = '0;
                        end else begin
                            run_nxt = run_cnt + RUN_ONE;
                        end
                    end else if (din_zero) begin
                        state_nxt = SEARCH;
                        pred_nxt  = '0;
                        run_nxt   = '0;
                    end else begin
                        // a wrong but legal word is taken as a fresh seed
                        pred_nxt = lfsr_nxt(din);
                        run_nxt  = '0;
                    end
                end
                LOCKED: begin
                    // flywheel: the predictor free-runs, never reseeded while locked
                    pred_nxt = lfsr_nxt(pred);
                    if (din_match) begin
                        miss_nxt = '0;
                    end else if (miss_cnt == MISS_LAST) begin
                        state_nxt = SEARCH;
                        pred_nxt  = '0;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + MISS_ONE;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    pred_nxt  = '0;
                    run_nxt   = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    // Error/zero pulses and the saturating error counter (clear beats increment)
    always_comb begin
        err_nxt  = din_vld && (state == LOCKED) && !din_match;
        zero_nxt = din_vld && din_zero;
        cnt_nxt  = err_cnt;
        if (clr_cnt) begin
            cnt_nxt = '0;
        end else if (err_nxt && !(&err_cnt)) begin
            cnt_nxt = err_cnt + CNT_ONE;
        end
    end

endmodule
